alu_writeback: RTL

Execution and write-back stage of the TD4 datapath, directly downstream of the 4:1 data selector. Adds the selector output to the instruction immediate and latches the sum into the A, B or OUT register, or into the program counter. Holds the carry flag consumed by the decoder for conditional jumps. Register outputs feed back into the selector inputs, and the PC drives the program ROM address.

---
 rtl/td4_pkg.sv | 15 +
 rtl/step_edge.sv | 25 ++
 rtl/alu_writeback.sv | 121 ++++++++++++
 3 files changed

// File: rtl/td4_pkg.sv
// td4_pkg: shared constants for the TD4 datapath (load-enable bit positions,
// load-vector width and default data width).
package td4_pkg;

  localparam int unsigned LD_WIDTH   = 4;
  localparam int unsigned DATA_WIDTH = 4;

  localparam int unsigned LD_A   = 0;
  localparam int unsigned LD_B   = 1;
  localparam int unsigned LD_OUT = 2;
  localparam int unsigned LD_PC  = 3;

  typedef logic [LD_WIDTH-1:0] ld_vec_t;

endpackage

// File: rtl/step_edge.sv
// step_edge: rising-edge detector on the single-step request level.
// EXEC is high on the clock edge where the previous STEP was 0 and the current
// STEP is 1. The delay flop resets to 1 so a STEP held high through reset
// release does not trigger an execute.
module step_edge (
  input  logic CLK,
  input  logic RST,
  input  logic STEP,
  output logic EXEC
);

  logic r_step_prev;

  // Delay flop holding the previous STEP level; resets high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_step_prev <= 1'b1;
    end else begin
      r_step_prev <= STEP;
    end
  end

  assign EXEC = STEP & ~r_step_prev;

endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: TD4 execute / write-back stage.
// Adds the selector output Y to the immediate IM and loads the sum into
// A, B, OUT and/or PC as selected by LD; otherwise PC increments. The carry
// flag captures the adder carry on every execute cycle.
// Optional feature macro: TD4_SINGLE_STEP_EN (adds STEP port; one instruction
// executes per rising STEP edge).
module alu_writeback
  import td4_pkg::*;
#(
  parameter int bitWidth = DATA_WIDTH
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [bitWidth-1:0] Y,
  input  logic [bitWidth-1:0] IM,
  input  logic [LD_WIDTH-1:0] LD,
`ifdef TD4_SINGLE_STEP_EN
  input  logic                STEP,
`endif
  output logic [bitWidth-1:0] REG_A,
  output logic [bitWidth-1:0] REG_B,
  output logic [bitWidth-1:0] OUT,
  output logic [bitWidth-1:0] PC,
  output logic                CF
);

  logic [bitWidth-1:0] r_a;
  logic [bitWidth-1:0] r_b;
  logic [bitWidth-1:0] r_out;
  logic [bitWidth-1:0] r_pc;
  logic                r_cf;

  logic                w_exec;
  logic [bitWidth:0]   w_full;
  logic [bitWidth-1:0] w_sum;
  logic                w_carry;

  logic [bitWidth-1:0] w_a_nxt;
  logic [bitWidth-1:0] w_b_nxt;
  logic [bitWidth-1:0] w_out_nxt;
  logic [bitWidth-1:0] w_pc_nxt;
  logic                w_cf_nxt;

`ifdef TD4_SINGLE_STEP_EN
  step_edge u_step_edge (
    .CLK  (CLK),
    .RST  (RST),
    .STEP (STEP),
    .EXEC (w_exec)
  );
`else
  assign w_exec = 1'b1;
`endif

  // Inline adder widened by one bit so the MSB is the carry.
  assign w_full  = {1'b0, Y} + {1'b0, IM};
  assign w_sum   = w_full[bitWidth-1:0];
  assign w_carry = w_full[bitWidth];

  // Next-state selection: load the sum where enabled, PC otherwise increments.
  always_comb begin
    w_a_nxt   = r_a;
    w_b_nxt   = r_b;
    w_out_nxt = r_out;
    w_pc_nxt  = r_pc;
    w_cf_nxt  = r_cf;
    if (w_exec) begin
      if (LD[LD_A]) begin
        w_a_nxt = w_sum;
      end else begin
        w_a_nxt = r_a;
      end
      if (LD[LD_B]) begin
        w_b_nxt = w_sum;
      end else begin
        w_b_nxt = r_b;
      end
      if (LD[LD_OUT]) begin
        w_out_nxt = w_sum;
      end else begin
        w_out_nxt = r_out;
      end
      if (LD[LD_PC]) begin
        w_pc_nxt = w_sum;
      end else begin
        w_pc_nxt = r_pc + {{(bitWidth-1){1'b0}}, 1'b1};
      end
      w_cf_nxt = w_carry;
    end else begin
      w_a_nxt   = r_a;
      w_b_nxt   = r_b;
      w_out_nxt = r_out;
      w_pc_nxt  = r_pc;
      w_cf_nxt  = r_cf;
    end
  end

  // Architectural state registers; synchronous reset dominates everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_a   <= {bitWidth{1'b0}};
      r_b   <= {bitWidth{1'b0}};
      r_out <= {bitWidth{1'b0}};
      r_pc  <= {bitWidth{1'b0}};
      r_cf  <= 1'b0;
    end else begin
      r_a   <= w_a_nxt;
      r_b   <= w_b_nxt;
      r_out <= w_out_nxt;
      r_pc  <= w_pc_nxt;
      r_cf  <= w_cf_nxt;
    end
  end

  assign REG_A = r_a;
  assign REG_B = r_b;
  assign OUT   = r_out;
  assign PC    = r_pc;
  assign CF    = r_cf;

endmodule
